output_port_scheduler: RTL
==========================

OUTPUT_PORT_SCHEDULER -- requirements
Module: output_port_scheduler

Interface
REQ-001 The block SHALL have parameter CREDITS, default 4, meaning the downstream buffer depth in flits (range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, meaning the number of stalled BUSY cycles before forced release (range 1..4095).
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, the reset: asynchronous, active-low.
REQ-005 Port req SHALL be an input, 5 bits, per-input request for this output; bit order L=0, N=1, E=2, W=3, S=4.
REQ-006 Port flit_valid SHALL be an input, 5 bits, meaning the requester's current flit is present.
REQ-007 Port tail SHALL be an input, 5 bits, meaning the requester's current flit is the packet tail.
REQ-008 Port credit_in SHALL be an input, 1 bit, a one-cycle pulse returning one downstream credit.
REQ-009 Port grant SHALL be an output, 5 bits, a registered one-hot grant or all-zero.
REQ-010 Port xbar_sel SHALL be an output, 3 bits, the encoded index of the granted input; 3'd7 when no grant.
REQ-011 Port flit_fire SHALL be an output, 1 bit, combinational, meaning one flit traverses this cycle.
REQ-012 Port credit_cnt SHALL be an output, 4 bits, the registered count of available downstream credits.
REQ-013 Port timeout_err SHALL be an output, 1 bit, a registered one-cycle pulse on watchdog release.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE (grant=0) and BUSY (grant one-hot, held constant).
REQ-015 In IDLE with req!=0, the block SHALL select a winner round-robin, searching upward (mod 5) from last_winner+1; the next cycle SHALL then show BUSY with grant=onehot(winner) and last_winner=winner.
REQ-016 In IDLE with req==0, the block SHALL stay in IDLE and leave last_winner unchanged.
REQ-017 flit_fire SHALL equal BUSY && flit_valid[w] && req[w] && credit_cnt!=0, where w is the granted index.
REQ-018 On flit_fire with tail[w]=1, the block SHALL return to IDLE next cycle; no new grant is issued in that same cycle, so there is a minimum one IDLE cycle between packets.
REQ-019 In BUSY with req[w]=0, the block SHALL release to IDLE next cycle without error.
REQ-020 The watchdog SHALL clear on entry to BUSY and on every flit_fire, and increment each BUSY cycle without fire.
REQ-021 When the watchdog reaches TIMEOUT, the block SHALL go to IDLE next cycle and pulse timeout_err for one cycle.
REQ-022 The watchdog SHALL be 12 bits wide and hold at 0 in IDLE.
REQ-023 credit_cnt SHALL be decremented by flit_fire alone, incremented by credit_in alone, and left unchanged when both occur in the same cycle.
REQ-024 credit_cnt SHALL saturate at CREDITS, ignoring credit_in at the maximum.
REQ-025 credit_cnt SHALL never go below 0, which is guaranteed by REQ-017.
REQ-026 Release priority in a single cycle SHALL be: tail fire, then req drop, then timeout; timeout_err SHALL not pulse when tail fires in the same cycle.
REQ-027 flit_valid and tail SHALL be ignored for non-granted inputs.

Reset
REQ-028 When rst is low, the block SHALL immediately force: state=IDLE, grant=0, xbar_sel=3'd7, credit_cnt=CREDITS, timeout_err=0, watchdog=0, last_winner=4 (so L wins first).
REQ-029 flit_fire SHALL be 0 throughout reset.
REQ-030 A reset asserted during BUSY SHALL abort the packet with no error pulse.
REQ-031 Reset release SHALL be synchronised by the user; the block SHALL not self-synchronise.

Structure
REQ-032 A shared package SHALL hold the port index constants (L..S), the NPORTS=5 constant, the state enum {IDLE, BUSY} and the NO_SEL=3'd7 constant.
REQ-033 The round-robin search SHALL be one combinational sub-module, rr_arbiter5 (inputs req and last_winner; outputs winner index and valid).
REQ-034 The FSM, watchdog and credit counter SHALL live in the top module.

Verification
REQ-035 Test: reset, then req=5'b10110 held with tails on every flit -> grants N, E, S, N in order, each BUSY separated by one IDLE cycle.
REQ-036 Test: grant E, CREDITS=4, flit_valid held, no credit_in -> exactly 4 flit_fire pulses, then credit_cnt=0 and fire stops; one credit_in -> one more fire.
REQ-037 Test: credit_in and flit_fire in the same cycle at credit_cnt=2 -> credit_cnt stays 2; credit_in at credit_cnt=4 -> stays 4.
REQ-038 Test: TIMEOUT=8, granted W with flit_valid=0 -> IDLE and a single timeout_err pulse 9 cycles after grant; next grant goes to S if requesting.
REQ-039 Test: granted L, drop req[0] mid-packet -> IDLE next cycle, timeout_err=0.
REQ-040 Test: assert rst during BUSY with credit_cnt=1 -> grant=0, xbar_sel=7, credit_cnt=4 immediately, before any clock edge.

Source files
------------

// File: rtl/output_port_scheduler_pkg.sv
// Shared constants and types for the output port scheduler.
// Port indices, port count, FSM state enum and the no-select code.
package output_port_scheduler_pkg;

  localparam int NPORTS = 5;

  localparam logic [2:0] P_L = 3'd0;
  localparam logic [2:0] P_N = 3'd1;
  localparam logic [2:0] P_E = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_S = 3'd4;

  localparam logic [2:0] NO_SEL = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Index reached by stepping `step` ports up from `base`, modulo NPORTS.
  function automatic logic [2:0] rr_next(
    input logic [2:0] base,
    input int         step
  );
    int s;
    s = (int'(base) + step) % NPORTS;
    return 3'(s);
  endfunction

endpackage

// File: rtl/output_port_scheduler_rr_arbiter5.sv
// Combinational 5-way round-robin search starting after last_winner.
// Ports: req, last_winner in; winner index and valid out.
module rr_arbiter5
  import output_port_scheduler_pkg::*;
(
  input  logic [4:0] req,
  input  logic [2:0] last_winner,
  output logic [2:0] winner,
  output logic       valid
);

  // Scan from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = NO_SEL;
    valid  = 1'b0;
    for (int i = NPORTS; i >= 1; i--) begin
      if (req[rr_next(last_winner, i)]) begin
        winner = rr_next(last_winner, i);
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/output_port_scheduler.sv
// Output port scheduler: round-robin packet grant, credits, watchdog.
// Ports: clk, rst(n), req/flit_valid/tail, credit_in; grant, xbar_sel, flit_fire, credit_cnt, timeout_err.
module output_port_scheduler
  import output_port_scheduler_pkg::*;
#(
  parameter int CREDITS = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic [4:0] flit_valid,
  input  logic [4:0] tail,
  input  logic       credit_in,
  output logic [4:0] grant,
  output logic [2:0] xbar_sel,
  output logic       flit_fire,
  output logic [3:0] credit_cnt,
  output logic       timeout_err
);

  localparam logic [3:0]  CRED_MAX = 4'(CREDITS);
  localparam logic [11:0] TO_MAX   = 12'(TIMEOUT);

  state_t      state;
  logic [2:0]  last_winner;
  logic [11:0] wdog;
  logic [2:0]  win;
  logic        win_v;

  logic req_w;
  logic tail_w;
  logic rel_tail;
  logic rel_drop;
  logic rel_to;

  rr_arbiter5 u_rr (
    .req         (req),
    .last_winner (last_winner),
    .winner      (win),
    .valid       (win_v)
  );

  // grant is one-hot or zero, so masking picks the granted input's bits.
  assign req_w  = |(grant & req);
  assign tail_w = |(grant & tail);

  assign flit_fire = (state == BUSY)
                   && |(grant & flit_valid & req)
                   && (credit_cnt != 4'd0);

  // Release reasons made mutually exclusive in priority order.
  // A fire implies req_w, so tail and drop never overlap.
  assign rel_tail = flit_fire & tail_w;
  assign rel_drop = ~req_w;
  assign rel_to   = req_w & ~rel_tail & (wdog == TO_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= 5'd0;
      xbar_sel    <= NO_SEL;
      last_winner <= P_S;
      wdog        <= 12'd0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      unique case (state)
        IDLE: begin
          wdog <= 12'd0;
          if (win_v) begin
            state       <= BUSY;
            grant       <= 5'b00001 << win;
            xbar_sel    <= win;
            last_winner <= win;
          end
        end
        BUSY: begin
          if (rel_tail | rel_drop | rel_to) begin
            state       <= IDLE;
            grant       <= 5'd0;
            xbar_sel    <= NO_SEL;
            wdog        <= 12'd0;
            timeout_err <= rel_to;
          end else if (flit_fire) begin
            wdog <= 12'd0;
          end else begin
            wdog <= wdog + 12'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant    <= 5'd0;
          xbar_sel <= NO_SEL;
          wdog     <= 12'd0;
        end
      endcase
    end
  end

  // Simultaneous fire and return cancel out; returns at max are dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_cnt <= CRED_MAX;
    end else begin
      unique case ({flit_fire, credit_in})
        2'b10: credit_cnt <= credit_cnt - 4'd1;
        2'b01: begin
          if (credit_cnt < CRED_MAX)
            credit_cnt <= credit_cnt + 4'd1;
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

endmodule
